// File: rtl/buyruk_hizalama_kuyrugu.sv
// Second fetch stage: packs L1I fetch blocks into a 16-bit parcel queue and hands
// realigned RV32IC instructions to decode, dropping responses made stale by a flush.
`timescale 1ns/1ps
module buyruk_hizalama_kuyrugu #(
  parameter int PS_BIT          = 32,
  parameter int OBEK_BIT        = 64,
  parameter int KUYRUK_DERINLIK = 8,
  parameter int MAKS_BEKLEYEN   = 4
) (
  input  logic                               clk_i,
  input  logic                               rstn_i,
  output logic                               g1_istek_hazir_o,
  input  logic                               g1_istek_yapildi_i,
  input  logic [OBEK_BIT-1:0]                l1b_obek_i,
  input  logic [PS_BIT-1:0]                  l1b_obek_ps_i,
  input  logic                               l1b_gecerli_i,
  output logic                               l1b_hazir_o,
  output logic [31:0]                        coz_buyruk_o,
  output logic [PS_BIT-1:0]                  coz_buyruk_ps_o,
  output logic                               coz_buyruk_rvc_o,
  output logic                               coz_gecerli_o,
  input  logic                               coz_hazir_i,
  input  logic                               cek_bosalt_i,
  output logic [$clog2(KUYRUK_DERINLIK):0]   kuyruk_doluluk_o
);

  localparam int P     = OBEK_BIT / 16;
  localparam int OFF_W = $clog2(P);
  localparam int PTR_W = $clog2(KUYRUK_DERINLIK);
  localparam int CNT_W = PTR_W + 1;
  localparam int BEK_W = $clog2(MAKS_BEKLEYEN + 1);

  logic [15:0]       kuyruk_r [KUYRUK_DERINLIK];
  logic [PTR_W-1:0]  yaz_r, oku_r;
  logic [CNT_W-1:0]  doluluk_r;
  logic [PS_BIT-1:0] bas_ps_r;
  logic [BEK_W-1:0]  bekleyen_r, atilacak_r;

  logic              kabul, tut, bas_rvc, bas_tam, yukle;
  logic [OFF_W-1:0]  off;
  logic [15:0]       p0, p1;
  logic [CNT_W-1:0]  yazilan, cekilen;

  // A block is kept only when no stale response is pending and no flush is in progress.
  assign kabul   = l1b_gecerli_i && l1b_hazir_o;
  assign tut     = kabul && (atilacak_r == '0) && !cek_bosalt_i;
  assign off     = l1b_obek_ps_i[OFF_W:1];
  assign yazilan = tut ? CNT_W'(P - int'(off)) : '0;

  assign p0      = kuyruk_r[oku_r];
  assign p1      = kuyruk_r[oku_r + PTR_W'(1)];
  assign bas_rvc = (p0[1:0] != 2'b11);
  assign bas_tam = bas_rvc ? (doluluk_r >= CNT_W'(1)) : (doluluk_r >= CNT_W'(2));
  assign yukle   = (!coz_gecerli_o || coz_hazir_i) && bas_tam && !cek_bosalt_i;
  assign cekilen = !yukle ? '0 : (bas_rvc ? CNT_W'(1) : CNT_W'(2));

  // Credit reserves a full block of room for every outstanding response that will be kept.
  assign g1_istek_hazir_o = (bekleyen_r < BEK_W'(MAKS_BEKLEYEN)) &&
                            ((int'(doluluk_r) + (int'(bekleyen_r) - int'(atilacak_r) + 1) * P)
                             <= KUYRUK_DERINLIK);
  assign l1b_hazir_o      = (bekleyen_r != '0);
  assign kuyruk_doluluk_o = doluluk_r;

  // NOTE: the parcel storage is reset too; it is small, and a defined reset image keeps
  // every head decode deterministic right after reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < KUYRUK_DERINLIK; i++) kuyruk_r[i] <= '0;
    end else if (tut) begin
      for (int j = 0; j < P; j++)
        if (j >= int'(off)) kuyruk_r[yaz_r + PTR_W'(j - int'(off))] <= l1b_obek_i[16*j +: 16];
    end
  end

  // NOTE: all state here uses non-blocking assignments so every branch reads the
  // pre-edge values of the counters and pointers, independent of statement order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      yaz_r            <= '0;
      oku_r            <= '0;
      doluluk_r        <= '0;
      bas_ps_r         <= '0;
      bekleyen_r       <= '0;
      atilacak_r       <= '0;
      coz_gecerli_o    <= 1'b0;
      coz_buyruk_o     <= '0;
      coz_buyruk_ps_o  <= '0;
      coz_buyruk_rvc_o <= 1'b0;
    end else begin
      if (cek_bosalt_i) begin
        yaz_r     <= '0;
        oku_r     <= '0;
        doluluk_r <= '0;
      end else begin
        yaz_r     <= yaz_r + yazilan[PTR_W-1:0];
        oku_r     <= oku_r + cekilen[PTR_W-1:0];
        doluluk_r <= doluluk_r + yazilan - cekilen;
      end

      // An empty queue cannot pop, so the two updates never collide.
      if (tut && doluluk_r == '0)
        bas_ps_r <= l1b_obek_ps_i;
      else if (yukle)
        bas_ps_r <= bas_ps_r + (bas_rvc ? PS_BIT'(2) : PS_BIT'(4));

      if (cek_bosalt_i) begin
        atilacak_r <= bekleyen_r - BEK_W'(kabul);
        bekleyen_r <= bekleyen_r - BEK_W'(kabul) + BEK_W'(g1_istek_yapildi_i);
      end else begin
        bekleyen_r <= bekleyen_r + BEK_W'(g1_istek_yapildi_i) - BEK_W'(kabul);
        if (kabul && atilacak_r != '0) atilacak_r <= atilacak_r - BEK_W'(1);
      end

      if (cek_bosalt_i) begin
        coz_gecerli_o <= 1'b0;
      end else if (yukle) begin
        coz_gecerli_o    <= 1'b1;
        coz_buyruk_o     <= bas_rvc ? {16'h0000, p0} : {p1, p0};
        coz_buyruk_ps_o  <= bas_ps_r;
        coz_buyruk_rvc_o <= bas_rvc;
      end else if (coz_hazir_i) begin
        coz_gecerli_o <= 1'b0;
      end
    end
  end

  a_istek_kredisi: assert property (@(posedge clk_i) disable iff (!rstn_i)
                                    g1_istek_yapildi_i |-> g1_istek_hazir_o);

endmodule

// File: tb/tb_buyruk_hizalama_kuyrugu.sv
// Bench for buyruk_hizalama_kuyrugu: directed scenarios then random traffic, all checked
// against a parcel-queue reference model with an in-order L1I responder.
`timescale 1ns/1ps
module tb_buyruk_hizalama_kuyrugu;
  localparam int P  = 4;
  localparam int D  = 8;
  localparam int MB = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        g1_istek_hazir_o, g1_istek_yapildi_i;
  logic [63:0] l1b_obek_i;
  logic [31:0] l1b_obek_ps_i;
  logic        l1b_gecerli_i, l1b_hazir_o;
  logic [31:0] coz_buyruk_o, coz_buyruk_ps_o;
  logic        coz_buyruk_rvc_o, coz_gecerli_o, coz_hazir_i, cek_bosalt_i;
  logic [3:0]  kuyruk_doluluk_o;

  buyruk_hizalama_kuyrugu dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .g1_istek_hazir_o(g1_istek_hazir_o), .g1_istek_yapildi_i(g1_istek_yapildi_i),
    .l1b_obek_i(l1b_obek_i), .l1b_obek_ps_i(l1b_obek_ps_i),
    .l1b_gecerli_i(l1b_gecerli_i), .l1b_hazir_o(l1b_hazir_o),
    .coz_buyruk_o(coz_buyruk_o), .coz_buyruk_ps_o(coz_buyruk_ps_o),
    .coz_buyruk_rvc_o(coz_buyruk_rvc_o), .coz_gecerli_o(coz_gecerli_o),
    .coz_hazir_i(coz_hazir_i), .cek_bosalt_i(cek_bosalt_i),
    .kuyruk_doluluk_o(kuyruk_doluluk_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [15:0] d; logic [31:0] ps; } parcel_t;
  typedef struct { logic [31:0] ps; logic [63:0] data; bit stale; } istek_t;

  parcel_t     mq[$];
  istek_t      rq[$];
  bit          m_v, m_rvc;
  logic [31:0] m_ins, m_ps, m_next_ps;
  int          n_check, n_fail;
  logic [31:0] f_ps;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_check++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_g1();
    int st;
    st = 0;
    foreach (rq[i]) if (rq[i].stale) st++;
    return (rq.size() < MB) && (mq.size() + (rq.size() - st + 1) * P <= D);
  endfunction

  task automatic compare_all();
    check("coz_gecerli", coz_gecerli_o, m_v);
    if (m_v) begin
      check("coz_buyruk", coz_buyruk_o, m_ins);
      check("coz_ps", coz_buyruk_ps_o, m_ps);
      check("coz_rvc", coz_buyruk_rvc_o, m_rvc);
    end
    check("doluluk", kuyruk_doluluk_o, mq.size());
    check("g1_hazir", g1_istek_hazir_o, exp_g1());
    check("l1b_hazir", l1b_hazir_o, rq.size() != 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_gecerli"}, coz_gecerli_o, 0);
    check({tag, "_rvc"}, coz_buyruk_rvc_o, 0);
    check({tag, "_buyruk"}, coz_buyruk_o, 0);
    check({tag, "_ps"}, coz_buyruk_ps_o, 0);
    check({tag, "_doluluk"}, kuyruk_doluluk_o, 0);
    check({tag, "_l1b_hazir"}, l1b_hazir_o, 0);
    check({tag, "_g1_hazir"}, g1_istek_hazir_o, 1);
  endtask

  task automatic model_reset();
    mq.delete();
    rq.delete();
    m_v = 0;
    m_next_ps = '0;
  endtask

  task automatic idle_inputs();
    g1_istek_yapildi_i = 0; l1b_gecerli_i = 0; l1b_obek_i = '0; l1b_obek_ps_i = '0;
    coz_hazir_i = 0; cek_bosalt_i = 0;
  endtask

  // One clock: drive inputs, advance the reference model, then compare after the edge.
  task automatic cycle(input bit req, input logic [31:0] req_ps, input logic [63:0] req_data,
                       input bit give, input bit hz, input bit fl);
    bit     acc, was_empty;
    istek_t h;
    int     off;
    acc = give && (rq.size() != 0);
    g1_istek_yapildi_i = req;
    l1b_gecerli_i      = acc;
    if (acc) begin
      h = rq[0];
      l1b_obek_i    = h.data;
      l1b_obek_ps_i = h.ps;
    end else begin
      l1b_obek_i    = {$urandom, $urandom};
      l1b_obek_ps_i = $urandom;
    end
    coz_hazir_i  = hz;
    cek_bosalt_i = fl;

    if (fl) begin
      m_v = 0;
      mq.delete();
    end else begin
      was_empty = (mq.size() == 0);
      if ((!m_v || hz) && mq.size() != 0 && (mq[0].d[1:0] != 2'b11 || mq.size() >= 2)) begin
        m_v   = 1;
        m_ps  = mq[0].ps;
        m_rvc = (mq[0].d[1:0] != 2'b11);
        m_ins = m_rvc ? {16'h0000, mq[0].d} : {mq[1].d, mq[0].d};
        void'(mq.pop_front());
        if (!m_rvc) void'(mq.pop_front());
      end else if (hz) begin
        m_v = 0;
      end
      if (acc && !h.stale) begin
        off = int'(h.ps[2:1]);
        if (was_empty) m_next_ps = h.ps;
        for (int k = off; k < P; k++) begin
          mq.push_back(parcel_t'{d: h.data[16*k +: 16], ps: m_next_ps});
          m_next_ps += 32'd2;
        end
      end
    end
    if (acc) void'(rq.pop_front());
    if (fl) foreach (rq[i]) rq[i].stale = 1;
    if (req) rq.push_back(istek_t'{ps: req_ps, data: req_data, stale: 1'b0});

    @(posedge clk_i); #1;
    compare_all();
  endtask

  initial begin
    bit          fl, req, r;
    logic [31:0] f;
    n_check = 0;
    n_fail  = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_reset("rst");
    rstn_i = 1'b1;

    // T1: two c.nop then addi split over parcels 2/3
    cycle(1, 32'h100, 64'h0010_8093_0001_0001, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    check("t1_no_bypass", coz_gecerli_o, 0);
    cycle(0, 0, 0, 0, 1, 0);
    check("t1_ps0", coz_buyruk_ps_o, 32'h100);
    check("t1_rvc0", coz_buyruk_rvc_o, 1);
    cycle(0, 0, 0, 0, 1, 0);
    check("t1_ps1", coz_buyruk_ps_o, 32'h102);
    cycle(0, 0, 0, 0, 1, 0);
    check("t1_addi", coz_buyruk_o, 32'h0010_8093);
    check("t1_ps2", coz_buyruk_ps_o, 32'h104);
    cycle(0, 0, 0, 0, 1, 0);

    // T2: lw straddling two blocks, first block entered at an unaligned PS
    cycle(1, 32'h106, 64'h2083_AAAA_AAAA_AAAA, 0, 1, 0);
    cycle(1, 32'h108, 64'h0001_0001_0001_0001, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    check("t2_lw", coz_buyruk_o, 32'h0001_2083);
    check("t2_ps", coz_buyruk_ps_o, 32'h106);
    check("t2_rvc", coz_buyruk_rvc_o, 0);
    repeat (4) cycle(0, 0, 0, 0, 1, 0);

    // T3: decode stall holds the output stable
    cycle(1, 32'h200, 64'h0001_0001_0001_0001, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    repeat (5) begin
      cycle(0, 0, 0, 0, 0, 0);
      check("t3_hold_ps", coz_buyruk_ps_o, 32'h200);
    end
    cycle(0, 0, 0, 0, 1, 0);
    check("t3_next_ps", coz_buyruk_ps_o, 32'h202);
    repeat (4) cycle(0, 0, 0, 0, 1, 0);

    // T4: flush with a request in the same cycle; stale response dropped
    cycle(1, 32'h300, {$urandom, $urandom}, 0, 1, 0);
    cycle(1, 32'h400, 64'h0001_0001_0001_0001, 0, 1, 1);
    cycle(1, 32'h408, 64'h0001_0001_0001_0001, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    check("t4_drop_doluluk", kuyruk_doluluk_o, 0);
    check("t4_drop_gecerli", coz_gecerli_o, 0);
    cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    check("t4_first_ps", coz_buyruk_ps_o, 32'h400);

    // T5: fill to the credit limit under a decode stall, then release
    f = 32'h500;
    repeat (16) begin
      r = exp_g1();
      cycle(r, f, 64'h0001_0001_0001_0001, 1, 0, 0);
      if (r) f += 32'd8;
    end
    check("t5_credit_full", g1_istek_hazir_o, 0);
    repeat (6) cycle(0, 0, 0, 0, 1, 0);
    check("t5_credit_free", g1_istek_hazir_o, 1);

    // T6: reset in mid-stream
    cycle(exp_g1(), 32'h600, {$urandom, $urandom}, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    rstn_i = 1'b0;
    idle_inputs();
    @(posedge clk_i); #1;
    check_reset("t6");
    model_reset();
    rstn_i = 1'b1;

    // Random traffic with occasional flushes
    f_ps = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      fl = ($urandom_range(0, 63) == 0);
      if (fl) f_ps = $urandom & 32'hFFFF_FFFE;
      req = exp_g1() && ($urandom_range(0, 3) != 0);
      cycle(req, f_ps, {$urandom, $urandom}, $urandom_range(0, 2) != 0,
            $urandom_range(0, 3) != 0, fl);
      if (req) f_ps = {f_ps[31:3], 3'b000} + 32'd8;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
    $finish;
  end

endmodule
